// File: rtl/retire_stage.sv
// Multi-way in-order retire stage: commits architectural mappings, frees stale physical
// registers, and raises a one-cycle squash or a sticky halt on precise/halt entries.
module retire_stage #(
  parameter int unsigned WAYS    = 2,
  parameter int unsigned N_ARCH  = 32,
  parameter int unsigned PR_BITS = 6,
  parameter int unsigned XLEN    = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [WAYS-1:0]                  ret_valid,
  input  logic [WAYS-1:0][PR_BITS-1:0]     ret_t_idx,
  input  logic [WAYS-1:0][PR_BITS-1:0]     ret_told_idx,
  input  logic [WAYS-1:0][4:0]             ret_ar_idx,
  input  logic [WAYS-1:0]                  ret_halt,
  input  logic [WAYS-1:0]                  ret_precise,
  input  logic [WAYS-1:0][XLEN-1:0]        ret_target_pc,
  output logic [WAYS-1:0]                  free_valid,
  output logic [WAYS-1:0][PR_BITS-1:0]     free_idx,
  output logic                             squash,
  output logic [XLEN-1:0]                  squash_pc,
  output logic [N_ARCH-1:0][PR_BITS-1:0]   arch_map,
  output logic                             halted,
  output logic [31:0]                      retired_count
);

  typedef enum logic [1:0] {StRun, StSquash, StHalt} state_e;

  state_e                           state_q, state_d;
  logic [N_ARCH-1:0][PR_BITS-1:0]   arch_map_q, arch_map_d;
  logic [WAYS-1:0]                  free_valid_q, free_valid_d;
  logic [WAYS-1:0][PR_BITS-1:0]     free_idx_q, free_idx_d;
  logic                             squash_q, squash_d;
  logic [XLEN-1:0]                  squash_pc_q, squash_pc_d;
  logic                             halted_q, halted_d;
  logic [31:0]                      count_q, count_d;
  logic                             stop;

  always_comb begin
    state_d      = state_q;
    arch_map_d   = arch_map_q;
    free_valid_d = '0;
    free_idx_d   = '0;
    squash_d     = 1'b0;
    squash_pc_d  = '0;
    halted_d     = halted_q;
    count_d      = count_q;
    stop         = 1'b0;
    unique case (state_q)
      StRun: begin
        // Slots are walked oldest first; the first halt/precise slot closes the group.
        for (int i = 0; i < int'(WAYS); i++) begin
          if (ret_valid[i] && !stop) begin
            count_d = count_d + 32'd1;
            if (ret_ar_idx[i] != 5'd0) begin
              arch_map_d[ret_ar_idx[i]] = ret_t_idx[i];
              free_valid_d[i]           = 1'b1;
              free_idx_d[i]             = ret_told_idx[i];
            end
            if (ret_halt[i]) begin
              halted_d = 1'b1;
              state_d  = StHalt;
              stop     = 1'b1;
            end else if (ret_precise[i]) begin
              squash_d    = 1'b1;
              squash_pc_d = ret_target_pc[i];
              state_d     = StSquash;
              stop        = 1'b1;
            end
          end
        end
      end
      StSquash: state_d = StRun;
      StHalt:   state_d = StHalt;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StRun;
      for (int r = 0; r < int'(N_ARCH); r++) begin
        arch_map_q[r] <= PR_BITS'(r);
      end
      free_valid_q <= '0;
      free_idx_q   <= '0;
      squash_q     <= 1'b0;
      squash_pc_q  <= '0;
      halted_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      arch_map_q   <= arch_map_d;
      free_valid_q <= free_valid_d;
      free_idx_q   <= free_idx_d;
      squash_q     <= squash_d;
      squash_pc_q  <= squash_pc_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
    end
  end

  assign arch_map      = arch_map_q;
  assign free_valid    = free_valid_q;
  assign free_idx      = free_idx_q;
  assign squash        = squash_q;
  assign squash_pc     = squash_pc_q;
  assign halted        = halted_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_retire_stage.sv
// Randomized bench for retire_stage against an in-order retirement reference model,
// preceded by directed scenarios for the documented corner cases.
module tb_retire_stage;
  localparam int WAYS = 2, N_ARCH = 32, PR_BITS = 6, XLEN = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [WAYS-1:0]                ret_valid, ret_halt, ret_precise;
  logic [WAYS-1:0][PR_BITS-1:0]   ret_t_idx, ret_told_idx;
  logic [WAYS-1:0][4:0]           ret_ar_idx;
  logic [WAYS-1:0][XLEN-1:0]      ret_target_pc;
  logic [WAYS-1:0]                free_valid;
  logic [WAYS-1:0][PR_BITS-1:0]   free_idx;
  logic                           squash;
  logic [XLEN-1:0]                squash_pc;
  logic [N_ARCH-1:0][PR_BITS-1:0] arch_map;
  logic                           halted;
  logic [31:0]                    retired_count;

  retire_stage #(.WAYS(WAYS), .N_ARCH(N_ARCH), .PR_BITS(PR_BITS), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .ret_valid(ret_valid), .ret_t_idx(ret_t_idx),
    .ret_told_idx(ret_told_idx), .ret_ar_idx(ret_ar_idx), .ret_halt(ret_halt),
    .ret_precise(ret_precise), .ret_target_pc(ret_target_pc), .free_valid(free_valid),
    .free_idx(free_idx), .squash(squash), .squash_pc(squash_pc), .arch_map(arch_map),
    .halted(halted), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what the outputs should read after the next edge.
  int                           m_map[N_ARCH];
  int unsigned                  m_count;
  bit                           m_halted, m_sq;
  bit [XLEN-1:0]                m_spc;
  bit [WAYS-1:0]                m_fv;
  bit [WAYS-1:0][PR_BITS-1:0]   m_fi;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < N_ARCH; r++) m_map[r] = r;
    m_count = 0; m_halted = 0; m_sq = 0; m_spc = 0; m_fv = 0; m_fi = 0;
  endtask

  task automatic model_step();
    bit run;
    run = !m_halted && !m_sq;  // squash visible now means this cycle is the SQUASH cycle
    m_fv = 0; m_fi = 0; m_sq = 0; m_spc = 0;
    if (run) begin
      for (int i = 0; i < WAYS; i++) begin
        if (!ret_valid[i]) continue;
        m_count++;
        if (ret_ar_idx[i] != 0) begin
          m_map[ret_ar_idx[i]] = ret_t_idx[i];
          m_fv[i] = 1'b1;
          m_fi[i] = ret_told_idx[i];
        end
        if (ret_halt[i]) begin m_halted = 1; break; end
        if (ret_precise[i]) begin m_sq = 1; m_spc = ret_target_pc[i]; break; end
      end
    end
  endtask

  task automatic step(input bit rst);
    logic [N_ARCH-1:0][PR_BITS-1:0] em;
    reset = rst;
    if (rst) model_reset(); else model_step();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int r = 0; r < N_ARCH; r++) em[r] = m_map[r][PR_BITS-1:0];
    check("arch_map", arch_map, em);
    check("free_valid", free_valid, m_fv);
    check("free_idx", free_idx, m_fi);
    check("squash", squash, m_sq);
    check("squash_pc", squash_pc, m_spc);
    check("halted", halted, m_halted);
    check("retired_count", retired_count, m_count);
  endtask

  task automatic clear_in();
    ret_valid = '0; ret_halt = '0; ret_precise = '0; ret_t_idx = '0;
    ret_told_idx = '0; ret_ar_idx = '0; ret_target_pc = '0;
  endtask

  task automatic set_slot(input int i, input int ar, input int t, input int told,
                          input bit h, input bit p, input logic [XLEN-1:0] pc);
    ret_valid[i] = 1'b1; ret_ar_idx[i] = 5'(ar); ret_t_idx[i] = PR_BITS'(t);
    ret_told_idx[i] = PR_BITS'(told); ret_halt[i] = h; ret_precise[i] = p;
    ret_target_pc[i] = pc;
  endtask

  initial begin
    clear_in();
    step(1'b1);
    check("rst_map7", arch_map[7], 6'd7);

    // Two independent destinations
    set_slot(0, 3, 40, 3, 0, 0, 0); set_slot(1, 5, 41, 5, 0, 0, 0);
    step(1'b0);
    check("d036_map3", arch_map[3], 6'd40);
    check("d036_fidx", free_idx, {6'd5, 6'd3});
    check("d036_cnt", retired_count, 32'd2);

    // Same destination twice: younger wins, both olds freed
    clear_in(); set_slot(0, 7, 42, 7, 0, 0, 0); set_slot(1, 7, 43, 42, 0, 0, 0);
    step(1'b0);
    check("d037_map7", arch_map[7], 6'd43);

    // Precise in slot 0 drops slot 1, then SQUASH cycle ignores input
    clear_in(); set_slot(0, 0, 0, 0, 0, 1, 32'h100); set_slot(1, 4, 44, 4, 0, 0, 0);
    step(1'b0);
    check("d038_sqpc", squash_pc, 32'h100);
    step(1'b0);
    check("d038_map4", arch_map[4], 6'd4);
    check("d038_cnt", retired_count, 32'd5);

    // Destination-less entry
    clear_in(); set_slot(0, 0, 0, 0, 0, 0, 0);
    step(1'b0);

    // Halt is sticky and masks later input; halt beats precise
    clear_in(); set_slot(0, 9, 50, 9, 1, 1, 32'h200); set_slot(1, 10, 51, 10, 0, 0, 0);
    step(1'b0);
    clear_in(); set_slot(0, 11, 52, 11, 0, 0, 0);
    step(1'b0);
    step(1'b0);
    check("d039_halted", halted, 1'b1);
    step(1'b1);

    // Reset during SQUASH cycle
    clear_in(); set_slot(0, 6, 45, 6, 0, 1, 32'h300);
    step(1'b0);
    step(1'b1);
    clear_in();
    step(1'b0);

    for (int n = 0; n < 600; n++) begin
      clear_in();
      for (int i = 0; i < WAYS; i++) begin
        ret_valid[i]     = ($urandom_range(0, 3) != 0);
        ret_ar_idx[i]    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        ret_t_idx[i]     = PR_BITS'($urandom);
        ret_told_idx[i]  = PR_BITS'($urandom);
        ret_halt[i]      = ($urandom_range(0, 39) == 0);
        ret_precise[i]   = ($urandom_range(0, 7) == 0);
        ret_target_pc[i] = $urandom;
      end
      step(($urandom_range(0, 49) == 0) || (m_halted && $urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
